// File: rtl/uart_apb_bridge.sv
// UART-to-APB debug bridge: 8N1 command frames in on uart_rx, one APB access per frame, status/data out on uart_tx.
// Latency: frame decode + 1 SETUP cycle + ACCESS until PREADY (or APB_TIMEOUT), then 1 or 5 response bytes.
// Backpressure: none on the serial side; bytes arriving while a transfer or response is in flight are dropped.
module uart_apb_bridge #(
  parameter int CLK_DIV      = 415,
  parameter int BYTE_TIMEOUT = 2000000,
  parameter int APB_TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [31:0] apb_PADDR,
  output logic        apb_PSEL,
  output logic        apb_PENABLE,
  output logic        apb_PWRITE,
  output logic [31:0] apb_PWDATA,
  input  logic        apb_PREADY,
  input  logic [31:0] apb_PRDATA,
  output logic        active
);

  localparam int CW  = $clog2(CLK_DIV + 1);
  localparam int BTW = $clog2(BYTE_TIMEOUT) + 1;
  localparam int ATW = $clog2(APB_TIMEOUT) + 1;
  localparam logic [CW-1:0]  HALF_M1  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1  = CW'(CLK_DIV - 1);
  localparam logic [BTW-1:0] BTO_LAST = BTW'(BYTE_TIMEOUT - 1);
  localparam logic [ATW-1:0] ATO_LAST = ATW'((APB_TIMEOUT == 0) ? 0 : APB_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t          state, state_nxt;
  logic            rx_s1, rx_s2, rx_prev, rx_busy, byte_vld, byte_ferr;
  logic [3:0]      rx_bit;
  logic [CW-1:0]   rx_cnt;
  logic [7:0]      rx_byte;
  logic            tx_busy, tx_rdy, tx_done, tx_vld;
  logic [3:0]      tx_bit;
  logic [CW-1:0]   tx_cnt;
  logic [9:0]      tx_shift;
  logic [7:0]      tx_dat;
  logic [1:0]      byte_idx;
  logic [BTW-1:0]  bto_cnt;
  logic [ATW-1:0]  ato_cnt;
  logic            ato_exp, resp_err;
  logic [2:0]      resp_idx, resp_n;
  logic [31:0]     rdata;

  // RX: two-flop synchroniser, start-bit qualification at half a bit, then mid-bit sampling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1; rx_busy <= 1'b0;
      rx_bit <= '0; rx_cnt <= '0; rx_byte <= '0; byte_vld <= 1'b0; byte_ferr <= 1'b0;
    end else begin
      rx_s1     <= uart_rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      byte_vld  <= 1'b0;
      byte_ferr <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_bit  <= '0;
          rx_cnt  <= HALF_M1;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= FULL_M1;
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_busy <= 1'b0;      // line back high: false start
          else       rx_bit  <= 4'd1;
        end else if (rx_bit <= 4'd8) begin
          rx_byte <= {rx_s2, rx_byte[7:1]};
          rx_bit  <= rx_bit + 4'd1;
        end else begin
          rx_busy   <= 1'b0;
          byte_vld  <= rx_s2;
          byte_ferr <= !rx_s2;
        end
      end
    end
  end

  // TX accepts the next byte on the last cycle of a stop bit so response bytes run back to back
  assign tx_done = tx_busy && (tx_cnt == '0) && (tx_bit == 4'd9);
  assign tx_rdy  = !tx_busy || tx_done;
  assign uart_tx = tx_busy ? tx_shift[0] : 1'b1;

  // TX: 10-bit shift register (start, 8 data LSB first, stop), CLK_DIV cycles per bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy <= 1'b0; tx_bit <= '0; tx_cnt <= '0; tx_shift <= '1;
    end else if (tx_vld && tx_rdy) begin
      tx_busy  <= 1'b1;
      tx_shift <= {1'b1, tx_dat, 1'b0};
      tx_bit   <= '0;
      tx_cnt   <= FULL_M1;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_bit   <= tx_bit + 4'd1;
        tx_cnt   <= FULL_M1;
      end
    end
  end

  assign ato_exp     = (APB_TIMEOUT != 0) && (ato_cnt == ATO_LAST);
  assign apb_PSEL    = (state == S_SETUP) || (state == S_ACCESS);
  assign apb_PENABLE = (state == S_ACCESS);
  assign active      = (state != S_IDLE);

  // Parser state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Parser next state and response byte request; a byte beats a simultaneous byte timeout
  always_comb begin
    state_nxt = state;
    tx_vld    = 1'b0;
    tx_dat    = 8'h00;
    case (state)
      S_IDLE:   if (byte_vld && (rx_byte == 8'h57 || rx_byte == 8'h52)) state_nxt = S_ADDR;
      S_ADDR: begin
        if (byte_vld) begin
          if (byte_idx == 2'd3) state_nxt = apb_PWRITE ? S_DATA : S_SETUP;
        end else if (byte_ferr || bto_cnt == BTO_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (byte_vld) begin
          if (byte_idx == 2'd3) state_nxt = S_SETUP;
        end else if (byte_ferr || bto_cnt == BTO_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (apb_PREADY || ato_exp) state_nxt = S_RESP;
      S_RESP: begin
        tx_vld = (resp_idx != resp_n);
        case (resp_idx)
          3'd0:    tx_dat = resp_err ? 8'h45 : 8'h4B;
          3'd1:    tx_dat = rdata[7:0];
          3'd2:    tx_dat = rdata[15:8];
          3'd3:    tx_dat = rdata[23:16];
          default: tx_dat = rdata[31:24];
        endcase
        if (resp_idx == resp_n && !tx_busy) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Parser datapath: field collection, timeout counters, read capture, response sequencing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      apb_PADDR <= '0; apb_PWDATA <= '0; apb_PWRITE <= 1'b0; rdata <= '0;
      byte_idx <= '0; bto_cnt <= '0; ato_cnt <= '0;
      resp_err <= 1'b0; resp_idx <= '0; resp_n <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (byte_vld && (rx_byte == 8'h57 || rx_byte == 8'h52)) begin
            apb_PWRITE <= (rx_byte == 8'h57);
            byte_idx   <= '0;
            bto_cnt    <= '0;
          end
        end
        S_ADDR, S_DATA: begin
          if (byte_vld) begin
            if (state == S_ADDR) apb_PADDR[{byte_idx, 3'b000} +: 8]  <= rx_byte;
            else                 apb_PWDATA[{byte_idx, 3'b000} +: 8] <= rx_byte;
            byte_idx <= byte_idx + 2'd1;
            bto_cnt  <= '0;
          end else if (bto_cnt != BTO_LAST) begin
            bto_cnt <= bto_cnt + 1'b1;
          end
        end
        S_SETUP: begin
          ato_cnt  <= '0;
          resp_idx <= '0;
        end
        S_ACCESS: begin
          if (apb_PREADY) begin
            rdata    <= apb_PRDATA;
            resp_err <= 1'b0;
            resp_n   <= apb_PWRITE ? 3'd1 : 3'd5;
          end else if (ato_exp) begin
            resp_err <= 1'b1;
            resp_n   <= 3'd1;
          end else if (ato_cnt != ATO_LAST) begin
            ato_cnt <= ato_cnt + 1'b1;
          end
        end
        S_RESP:  if (tx_vld && tx_rdy) resp_idx <= resp_idx + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Directed bench for uart_apb_bridge: frame table plus hand-written framing, timeout and reset sequences.
// Latency: response bytes are decoded by a serial monitor and compared after the bridge returns to idle.
// Backpressure: the APB target inserts per-vector wait states or never answers.
module tb_uart_apb_bridge;
  localparam int CLK_DIV = 8;
  localparam int BYTE_TO = 1000;
  localparam int APB_TO  = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx, apb_PSEL, apb_PENABLE, apb_PWRITE, active;
  logic [31:0] apb_PADDR, apb_PWDATA;
  logic        apb_PREADY;
  logic [31:0] apb_PRDATA;

  always #5 clk = ~clk;

  uart_apb_bridge #(.CLK_DIV(CLK_DIV), .BYTE_TIMEOUT(BYTE_TO), .APB_TIMEOUT(APB_TO)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .apb_PADDR(apb_PADDR), .apb_PSEL(apb_PSEL), .apb_PENABLE(apb_PENABLE),
    .apb_PWRITE(apb_PWRITE), .apb_PWDATA(apb_PWDATA), .apb_PREADY(apb_PREADY),
    .apb_PRDATA(apb_PRDATA), .active(active)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // APB target: ready after ws wait states, or never when hang is set
  int          ws = 0;
  bit          hang = 1'b0;
  logic [31:0] prdata = '0;
  int          wctr = 0;
  always @(posedge clk) wctr <= (apb_PSEL && apb_PENABLE) ? wctr + 1 : 0;
  assign apb_PREADY = !hang && (wctr >= ws);
  assign apb_PRDATA = prdata;

  // APB observer
  int          n_setup = 0, n_acc = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic        cap_wr = 1'b0;
  always @(negedge clk) begin
    if (apb_PSEL && !apb_PENABLE) n_setup++;
    if (apb_PSEL && apb_PENABLE) begin
      if (n_acc == 0) begin
        cap_addr = apb_PADDR; cap_wdata = apb_PWDATA; cap_wr = apb_PWRITE;
      end
      n_acc++;
    end
  end

  // Serial decoder for uart_tx: records each byte and the cycle its start bit began
  logic [7:0] rq[$];
  int         tq[$];
  int         stop_bad = 0;
  initial begin : txmon
    logic       prev;
    logic [7:0] b;
    int         t0;
    prev = 1'b1;
    b = '0;
    forever begin
      @(negedge clk);
      if (prev && !uart_tx && reset_n) begin
        t0 = cyc;
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        if (uart_tx !== 1'b1) stop_bad++;
        rq.push_back(b);
        tq.push_back(t0);
      end
      prev = uart_tx;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input bit wr, input logic [31:0] addr, input logic [31:0] data, input int gap);
    send_byte(wr ? 8'h57 : 8'h52, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send_byte(addr[8*i +: 8], 1'b1);
      if (i == 1 && gap > 0) idle(gap);
    end
    if (wr) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], 1'b1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (active && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, active}, 32'd0);
  endtask

  task automatic clear_obs();
    n_setup = 0; n_acc = 0;
    rq.delete(); tq.delete();
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;     // write data, or target read data for reads
    int          ws;
    bit          hang;
    int          gap;      // idle cycles after the second address byte
    int          exp_acc;
    int          exp_n;
    logic [39:0] exp_resp; // response bytes, first byte in [7:0]
  } vec_t;

  vec_t        vt[5];
  logic [31:0] last_wdata;

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 0, 1'b0, 0,   1,  1, 40'h00_0000_004B};
    vt[1] = '{1'b0, 32'h4000_0004, 32'h1234_5678, 3, 1'b0, 0,   4,  5, 40'h12_3456_784B};
    vt[2] = '{1'b0, 32'h4000_0008, 32'h0000_0000, 0, 1'b1, 0,   16, 1, 40'h00_0000_0045};
    vt[3] = '{1'b1, 32'h0000_0100, 32'hA5A5_0001, 2, 1'b0, 900, 3,  1, 40'h00_0000_004B};
    vt[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_00FF, 0, 1'b0, 0,   1,  5, 40'h00_0000_FF4B};
    last_wdata = '0;

    // Reset state
    idle(2);
    check("rst uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst psel", {31'd0, apb_PSEL}, 32'd0);
    check("rst penable", {31'd0, apb_PENABLE}, 32'd0);
    check("rst pwrite", {31'd0, apb_PWRITE}, 32'd0);
    check("rst paddr", apb_PADDR, 32'd0);
    check("rst pwdata", apb_PWDATA, 32'd0);
    check("rst active", {31'd0, active}, 32'd0);
    reset_n = 1'b1;
    idle(10);

    // Garbage byte, framing error during ADDR, short glitch
    clear_obs();
    send_byte(8'hAA, 1'b1);
    idle(20);
    check("garbage active", {31'd0, active}, 32'd0);
    send_byte(8'h57, 1'b1);
    idle(4);
    check("cmd active", {31'd0, active}, 32'd1);
    send_byte(8'h3C, 1'b0);
    idle(20);
    check("ferr active", {31'd0, active}, 32'd0);
    uart_rx = 1'b0;
    idle(CLK_DIV / 4);
    uart_rx = 1'b1;
    idle(40);
    check("glitch active", {31'd0, active}, 32'd0);
    check("garbage setups", n_setup, 32'd0);
    check("garbage resp", rq.size(), 32'd0);

    // Frame table
    for (int i = 0; i < 5; i++) begin
      ws = vt[i].ws;
      hang = vt[i].hang;
      prdata = vt[i].wr ? 32'h0BAD_0BAD : vt[i].data;
      clear_obs();
      send_frame(vt[i].wr, vt[i].addr, vt[i].data, vt[i].gap);
      wait_idle($sformatf("v%0d idle", i), 3000);
      idle(4);
      if (vt[i].wr) last_wdata = vt[i].data;
      check($sformatf("v%0d setup", i), n_setup, 32'd1);
      check($sformatf("v%0d access", i), n_acc, vt[i].exp_acc);
      check($sformatf("v%0d paddr", i), cap_addr, vt[i].addr);
      check($sformatf("v%0d pwrite", i), {31'd0, cap_wr}, {31'd0, vt[i].wr});
      check($sformatf("v%0d pwdata", i), cap_wdata, last_wdata);
      check($sformatf("v%0d paddr hold", i), apb_PADDR, vt[i].addr);
      check($sformatf("v%0d pwdata hold", i), apb_PWDATA, last_wdata);
      check($sformatf("v%0d psel after", i), {31'd0, apb_PSEL}, 32'd0);
      check($sformatf("v%0d resp count", i), rq.size(), vt[i].exp_n);
      for (int k = 0; k < vt[i].exp_n; k++) begin
        if (k < rq.size()) begin
          check($sformatf("v%0d resp byte %0d", i, k), {24'd0, rq[k]}, {24'd0, vt[i].exp_resp[8*k +: 8]});
          if (k > 0) check($sformatf("v%0d byte spacing %0d", i, k), tq[k] - tq[k-1], 10 * CLK_DIV);
        end
      end
    end
    hang = 1'b0;
    check("stop bits", stop_bad, 32'd0);

    // Byte timeout mid-frame: frame discarded, later bytes are not commands
    clear_obs();
    send_byte(8'h52, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(1001);
    check("bto active", {31'd0, active}, 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h40, 1'b1);
    idle(40);
    check("bto active end", {31'd0, active}, 32'd0);
    check("bto setups", n_setup, 32'd0);
    check("bto resp", rq.size(), 32'd0);

    // Reset asserted during ACCESS
    hang = 1'b1;
    clear_obs();
    send_frame(1'b0, 32'h4000_000C, 32'd0, 0);
    begin
      int k;
      k = 0;
      while (!(apb_PSEL && apb_PENABLE) && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    check("rst2 in access", {31'd0, apb_PENABLE}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst2 psel", {31'd0, apb_PSEL}, 32'd0);
    check("rst2 penable", {31'd0, apb_PENABLE}, 32'd0);
    check("rst2 uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst2 active", {31'd0, active}, 32'd0);
    check("rst2 paddr", apb_PADDR, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    hang = 1'b0;
    ws = 1;
    prdata = 32'hCAFE_F00D;
    idle(10);
    clear_obs();
    send_frame(1'b0, 32'h4000_0020, 32'd0, 0);
    wait_idle("post rst idle", 3000);
    idle(4);
    check("post rst access", n_acc, 32'd2);
    check("post rst paddr", cap_addr, 32'h4000_0020);
    check("post rst resp count", rq.size(), 32'd5);
    if (rq.size() == 5) begin
      check("post rst resp", {rq[4], rq[3], rq[2], rq[1]}, 32'hCAFE_F00D);
      check("post rst status", {24'd0, rq[0]}, 32'h4B);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_apb_bridge.md
Name: uart_apb_bridge

Overview:
- UART-to-APB debug bridge: APB initiator driven by a host over a serial line.
- Receives framed command bytes (8N1), issues one APB read or write per frame, and returns the status and data on uart_tx.
- Sits beside the CPU as a second APB initiator. It drives peripherals such as the UART controller and config registers for bring-up and test without software.

Parameters:
CLK_DIV, 415, clock cycles per UART bit (same for rx and tx); must be >= 4
BYTE_TIMEOUT, 2000000, max idle cycles between bytes of one frame before the partial frame is discarded
APB_TIMEOUT, 65535, max cycles in ACCESS waiting for apb_PREADY; 0 = wait forever

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
uart_rx  in  1  serial input, idle high
uart_tx  out  1  serial output, idle high
apb_PADDR  out  32  APB address
apb_PSEL  out  1  APB select
apb_PENABLE  out  1  APB enable
apb_PWRITE  out  1  APB direction, 1 = write
apb_PWDATA  out  32  APB write data
apb_PREADY  in  1  APB ready from the target
apb_PRDATA  in  32  APB read data
active  out  1  high whenever the parser is not in IDLE

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (reset_n).
- Reset values: uart_tx=1, apb_PSEL=0, apb_PENABLE=0, apb_PWRITE=0, apb_PADDR=0, apb_PWDATA=0, active=0.
- Reset asserted mid-frame or mid-transfer aborts immediately. All counters clear and all of the above values are forced.
- RX synchroniser: uart_rx passes through a 2-flop synchroniser; all RX decisions use the synchronised value.
- RX start bit:
  - Falling edge starts the start-bit check; the line is resampled CLK_DIV/2 cycles later.
  - If high at that point, it is a false start: go back to waiting for an edge.
- RX data bits: 8 bits, LSB first, each sampled CLK_DIV cycles after the previous sample.
- RX stop bit:
  - Sampled CLK_DIV cycles after data bit 7.
  - Stop=0 is a framing error: the byte is dropped and the parser returns to IDLE.
  - Stop=1 produces a one-cycle byte_valid pulse to the parser.
- TX framing: start bit (0), 8 data bits LSB first, then stop bit (1); each bit lasts exactly CLK_DIV cycles. Back-to-back response bytes are sent with no extra idle.
- Frame format, all multi-byte fields little-endian:
  - Write: 0x57, addr[4], data[4].
  - Read: 0x52, addr[4].
- Parser states: IDLE, ADDR, DATA, SETUP, ACCESS, RESP.
  - IDLE: byte 0x57 or 0x52 latches the direction and moves to ADDR. Any other byte is ignored and the state stays IDLE.
  - ADDR: collects 4 bytes into apb_PADDR, byte 0 into bits [7:0]. Then goes to DATA if write, SETUP if read.
  - DATA: collects 4 bytes into apb_PWDATA, then goes to SETUP.
  - SETUP (1 cycle): apb_PSEL=1, apb_PENABLE=0, apb_PWRITE per command. Next state ACCESS.
  - ACCESS: apb_PSEL=1, apb_PENABLE=1, held until apb_PREADY=1.
    - On that cycle, apb_PRDATA is captured for reads; the next cycle has PSEL=PENABLE=0 and the state is RESP.
    - If APB_TIMEOUT!=0 and APB_TIMEOUT cycles elapse with PREADY=0, PSEL/PENABLE drop and the state moves to RESP with error status.
  - RESP:
    - Transmits the status byte: 0x4B ('K') on success, 0x45 ('E') on timeout.
    - A successful read then sends 4 data bytes, LSB byte first.
    - After the last stop bit completes, the state returns to IDLE.
- Address and data: apb_PADDR and apb_PWDATA hold their values after the transfer until the next frame overwrites them.
- Byte timeout: in ADDR or DATA, BYTE_TIMEOUT cycles without byte_valid discards the partial frame and returns to IDLE. No response is sent.
- Busy drop: bytes completing while in SETUP, ACCESS or RESP are discarded and do not affect the parser.
- Simultaneous events: byte_valid on the same cycle the byte timeout expires means the byte wins and the timeout counter reloads.
- Counter widths: bit counters are sized by $clog2(CLK_DIV+1); timeout counters by $clog2 of their parameter plus 1. There is no wrap-around; counters saturate at their terminal count.

Test Plan:
- Write, PREADY tied high. Send 57 10 00 00 40 EF BE AD DE -> one SETUP cycle, then one ACCESS cycle with PADDR=0x40000010, PWDATA=0xDEADBEEF, PWRITE=1; uart_tx returns 0x4B.
- Read with 3 wait states, PRDATA=0x12345678. Send 52 04 00 00 40 -> PENABLE high for 4 cycles, PWRITE=0; uart_tx returns 4B 78 56 34 12 with bit time = CLK_DIV cycles.
- APB timeout, APB_TIMEOUT=16, PREADY held low. Send a read frame -> PSEL drops after 16 ACCESS cycles; uart_tx returns only 0x45; active=0 afterwards.
- Garbage and framing. Send 0xAA, then a byte with stop bit 0 during ADDR, then a glitch low for CLK_DIV/4 -> no APB activity, active=0; a following valid write frame executes normally.
- Byte timeout, BYTE_TIMEOUT=1000. Send 52 04 00, idle 1001 cycles, then 00 40 -> no APB transfer and no response; active returns to 0.
- Reset mid-ACCESS. Pull reset_n low while PSEL=1 -> PSEL, PENABLE and uart_tx go to their reset values immediately (asynchronously); after release, a new read frame works.
